// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: memory-stage FSM states, OPCode field positions
// and the control bits latched alongside an outstanding memory access.
package cpu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  localparam int RD_LSB    = 0;
  localparam int RD_MSB    = 4;
  localparam int IMM16_LSB = 5;
  localparam int IMM16_MSB = 20;
  localparam int HW_LSB    = 21;
  localparam int HW_MSB    = 22;

  // Writeback controls captured with the access so the result can retire on the ack
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem2reg;
    logic       ldurb;
  } acc_ctrl_t;

  function automatic logic is_mem_op(input logic valid, input logic mem_write,
                                     input logic read_enable);
    return valid & (mem_write | read_enable);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and
// the data memory (slave).
interface mem_stage_if #(
  parameter int DW = 64,
  parameter int AW = 64
) ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_size;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/register.sv
// Generic enabled register with asynchronous active-low clear, used for the
// access and MEM/WB pipeline registers.
module register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wide_imm.sv
// MOVZ/MOVK result formation: imm16 placed in halfword hw, over zeros (MOVZ)
// or over the old Rd value (MOVK).
module wide_imm #(
  parameter int DW = 64
) (
  input  logic [15:0]   imm16,
  input  logic [1:0]    hw,
  input  logic [DW-1:0] old_value,
  output logic [DW-1:0] movz_value,
  output logic [DW-1:0] movk_value
);

  localparam int NHW = DW / 16;

  genvar gi;
  generate
    for (gi = 0; gi < NHW; gi++) begin : g_halfword
      localparam logic [1:0] SEL = 2'(gi);
      assign movz_value[gi*16 +: 16] = (hw == SEL) ? imm16 : 16'h0000;
      assign movk_value[gi*16 +: 16] = (hw == SEL) ? imm16 : old_value[gi*16 +: 16];
    end
  endgenerate

endmodule

// File: rtl/mem_stage.sv
// LEGv8 memory-access stage: runs a variable-latency req/ack transaction for
// loads and stores, forms MOVZ/MOVK results and drives the MEM/WB register.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic [DW-1:0] ALUOut,
  input  logic [DW-1:0] Db,
  input  logic [31:0]   OPCode,
  input  logic          MemWrite,
  input  logic          read_enable,
  input  logic          Mem2Reg,
  input  logic          RegWrite,
  input  logic          MOVZ,
  input  logic          MOVK,
  input  logic          LDURB,
  input  logic [3:0]    xfer_size,
  output logic          stall,
  mem_stage_if.master   mem,
  output logic          wb_valid,
  output logic          wb_RegWrite,
  output logic [4:0]    wb_Rd,
  output logic [DW-1:0] wb_data
);

  mem_state_t    state_reg;
  mem_state_t    state_next;
  logic          mem_op;
  logic          accept;
  logic          retire;
  logic          req_next;

  acc_ctrl_t     acc_ctrl_next;
  acc_ctrl_t     acc_ctrl;

  logic [DW-1:0] movz_value;
  logic [DW-1:0] movk_value;
  logic [DW-1:0] nonmem_data;
  logic [DW-1:0] load_data;

  logic          wb_valid_next;
  logic          wb_regwrite_next;
  logic [4:0]    wb_rd_next;
  logic [DW-1:0] wb_data_next;

  logic          unused_opcode;

  assign mem_op        = is_mem_op(valid_in, MemWrite, read_enable);
  assign unused_opcode = ^OPCode[31:HW_MSB+1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    accept     = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_op) begin
          accept     = 1'b1;
          stall      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (mem.mem_ack) begin
          retire     = 1'b1;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request is a register so it drops on the ack edge and again asynchronously on reset
  assign req_next = (state_next == ACCESS);

  register #(.W(1)) u_req (
    .clk(clk), .reset(reset), .en(1'b1), .d(req_next), .q(mem.mem_req)
  );

  register #(.W(1)) u_acc_we (
    .clk(clk), .reset(reset), .en(accept), .d(MemWrite), .q(mem.mem_we)
  );

  register #(.W(AW)) u_acc_addr (
    .clk(clk), .reset(reset), .en(accept), .d(AW'(ALUOut)), .q(mem.mem_addr)
  );

  register #(.W(DW)) u_acc_wdata (
    .clk(clk), .reset(reset), .en(accept), .d(Db), .q(mem.mem_wdata)
  );

  register #(.W(4)) u_acc_size (
    .clk(clk), .reset(reset), .en(accept), .d(xfer_size), .q(mem.mem_size)
  );

  always_comb begin
    acc_ctrl_next           = '0;
    acc_ctrl_next.rd        = OPCode[RD_MSB:RD_LSB];
    acc_ctrl_next.reg_write = RegWrite;
    acc_ctrl_next.mem2reg   = Mem2Reg;
    acc_ctrl_next.ldurb     = LDURB;
  end

  register #(.W($bits(acc_ctrl_t))) u_acc_ctrl (
    .clk(clk), .reset(reset), .en(accept), .d(acc_ctrl_next), .q(acc_ctrl)
  );

  wide_imm #(.DW(DW)) u_wide_imm (
    .imm16     (OPCode[IMM16_MSB:IMM16_LSB]),
    .hw        (OPCode[HW_MSB:HW_LSB]),
    .old_value (Db),
    .movz_value(movz_value),
    .movk_value(movk_value)
  );

  always_comb begin
    nonmem_data = ALUOut;
    if (MOVZ) begin
      nonmem_data = movz_value;
    end else if (MOVK) begin
      nonmem_data = movk_value;
    end
  end

  assign load_data = acc_ctrl.ldurb ? {{(DW-8){1'b0}}, mem.mem_rdata[7:0]} : mem.mem_rdata;

  // Rd/data follow the input path on bubbles; only valid/RegWrite are forced low
  always_comb begin
    wb_valid_next    = 1'b0;
    wb_regwrite_next = 1'b0;
    wb_rd_next       = OPCode[RD_MSB:RD_LSB];
    wb_data_next     = nonmem_data;
    if (retire) begin
      wb_valid_next    = 1'b1;
      wb_regwrite_next = acc_ctrl.reg_write & ~mem.mem_we;
      wb_rd_next       = acc_ctrl.rd;
      wb_data_next     = acc_ctrl.mem2reg ? load_data : DW'(mem.mem_addr);
    end else if ((state_reg == IDLE) && !mem_op) begin
      wb_valid_next    = valid_in;
      wb_regwrite_next = valid_in & RegWrite;
    end
  end

  register #(.W(1)) u_wb_valid (
    .clk(clk), .reset(reset), .en(1'b1), .d(wb_valid_next), .q(wb_valid)
  );

  register #(.W(1)) u_wb_regwrite (
    .clk(clk), .reset(reset), .en(1'b1), .d(wb_regwrite_next), .q(wb_RegWrite)
  );

  register #(.W(5)) u_wb_rd (
    .clk(clk), .reset(reset), .en(1'b1), .d(wb_rd_next), .q(wb_Rd)
  );

  register #(.W(DW)) u_wb_data (
    .clk(clk), .reset(reset), .en(1'b1), .d(wb_data_next), .q(wb_data)
  );

  // Memory relies on the request fields holding steady until it acknowledges
  a_req_stable: assert property (@(posedge clk) disable iff (!reset)
    (mem.mem_req && !mem.mem_ack) |=> ($stable(mem.mem_addr) && $stable(mem.mem_wdata)));

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed and random instruction stream,
// memory responder with per-request latency, scoreboarded writeback monitor.
module tb_mem_stage;
  import cpu_pkg::*;

  localparam int DW = 64;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in;
  logic [DW-1:0] ALUOut;
  logic [DW-1:0] Db;
  logic [31:0]   OPCode;
  logic          MemWrite, read_enable, Mem2Reg, RegWrite, MOVZ, MOVK, LDURB;
  logic [3:0]    xfer_size;
  logic          stall;
  logic          wb_valid;
  logic          wb_RegWrite;
  logic [4:0]    wb_Rd;
  logic [DW-1:0] wb_data;

  mem_stage_if #(.DW(DW), .AW(AW)) mem_bus ();

  mem_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ALUOut(ALUOut), .Db(Db),
    .OPCode(OPCode), .MemWrite(MemWrite), .read_enable(read_enable),
    .Mem2Reg(Mem2Reg), .RegWrite(RegWrite), .MOVZ(MOVZ), .MOVK(MOVK),
    .LDURB(LDURB), .xfer_size(xfer_size), .stall(stall), .mem(mem_bus.master),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_Rd(wb_Rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] db;
    logic [31:0] op;
    logic        mw, re, m2r, rw, movz, movk, ldurb;
    logic [3:0]  size;
  } instr_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  size;
    int          lat;
    logic [63:0] rdata;
  } mreq_t;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] data;
    int          cyc;
  } wb_t;

  mreq_t mem_q[$];
  wb_t   exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    stray_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference result from the architectural rules
  function automatic wb_t model(input instr_t ins, input logic [63:0] rdata, input int at);
    wb_t         e;
    logic [63:0] imm;
    int          sh;
    imm    = 64'(ins.op[IMM16_MSB:IMM16_LSB]);
    sh     = 16 * int'(ins.op[HW_MSB:HW_LSB]);
    e.rd   = ins.op[RD_MSB:RD_LSB];
    e.cyc  = at;
    e.rw   = ins.rw;
    e.data = ins.alu;
    if (ins.re && !ins.mw) begin
      e.data = ins.ldurb ? (rdata % 256) : rdata;
    end else if (ins.mw) begin
      e.rw = 1'b0;
    end else if (ins.movz) begin
      e.data = imm * (64'd1 << sh);
    end else if (ins.movk) begin
      e.data = (ins.db & ~(64'hFFFF << sh)) | (imm << sh);
    end
    return e;
  endfunction

  function automatic instr_t rand_base();
    instr_t ins;
    ins.alu   = {$urandom, $urandom};
    ins.db    = {$urandom, $urandom};
    ins.op    = $urandom;
    ins.mw    = 1'b0; ins.re   = 1'b0; ins.m2r  = 1'b0; ins.rw = 1'b0;
    ins.movz  = 1'b0; ins.movk = 1'b0; ins.ldurb = 1'b0;
    ins.size  = 4'd8;
    return ins;
  endfunction

  task automatic drive(input instr_t ins, input bit vld);
    valid_in    = vld;
    ALUOut      = ins.alu;
    Db          = ins.db;
    OPCode      = ins.op;
    MemWrite    = ins.mw;
    read_enable = ins.re;
    Mem2Reg     = ins.m2r;
    RegWrite    = ins.rw;
    MOVZ        = ins.movz;
    MOVK        = ins.movk;
    LDURB       = ins.ldurb;
    xfer_size   = ins.size;
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the op
  task automatic issue(input instr_t ins, input int lat, input logic [63:0] rdata, input bit vld);
    bit    memop;
    int    p;
    int    stall_cnt;
    mreq_t r;
    memop = vld && (ins.mw || ins.re);
    p     = cyc;
    drive(ins, vld);
    if (memop) begin
      r.we = ins.mw; r.addr = ins.alu; r.wdata = ins.db; r.size = ins.size;
      r.lat = lat; r.rdata = rdata;
      mem_q.push_back(r);
    end
    if (vld) exp_q.push_back(model(ins, rdata, memop ? p + lat + 2 : p + 1));
    stall_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!stall) break;
      stall_cnt++;
    end
    if (stall_cnt >= 64) fail("accept_timeout");
    else check("stall_cycles", 64'(stall_cnt), memop ? 64'(lat + 1) : 64'd0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  // Memory responder: acks each request after its scheduled latency
  initial begin
    mreq_t cur;
    bit    active;
    int    ncyc;
    active = 1'b0;
    ncyc   = 0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        active = 1'b0;
        mem_bus.mem_ack = 1'b0;
      end else if (mem_bus.mem_ack) begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = {$urandom, $urandom};
        check("req_low_after_ack", 64'(mem_bus.mem_req), 64'd0);
      end else if (stray_ack) begin
        stray_ack         = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = {$urandom, $urandom};
      end else if (mem_bus.mem_req) begin
        if (!active) begin
          if (mem_q.size() == 0) begin
            fail("unexpected_request");
          end else begin
            cur    = mem_q.pop_front();
            active = 1'b1;
            ncyc   = 0;
          end
        end
        if (active) begin
          check("mem_we", 64'(mem_bus.mem_we), 64'(cur.we));
          check("mem_addr", mem_bus.mem_addr, cur.addr);
          check("mem_wdata", mem_bus.mem_wdata, cur.wdata);
          check("mem_size", 64'(mem_bus.mem_size), 64'(cur.size));
          if (ncyc == cur.lat) begin
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = cur.rdata;
            active            = 1'b0;
          end
          ncyc++;
        end
      end else if (active) begin
        fail("request_withdrawn");
        active = 1'b0;
      end
    end
  end

  // Writeback monitor
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (wb_valid) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_retire");
          end else begin
            e = exp_q.pop_front();
            check("wb_Rd", 64'(wb_Rd), 64'(e.rd));
            check("wb_RegWrite", 64'(wb_RegWrite), 64'(e.rw));
            check("wb_data", wb_data, e.data);
            check("retire_cycle", 64'(cyc), 64'(e.cyc));
          end
        end else begin
          check("bubble_regwrite", 64'(wb_RegWrite), 64'd0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t ins;
    int     kind;
    int     lat;

    drive(rand_base(), 1'b0);
    #1 reset = 1'b0;
    #20;
    check("rst_mem_req", 64'(mem_bus.mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_bus.mem_we), 64'd0);
    check("rst_mem_addr", mem_bus.mem_addr, 64'd0);
    check("rst_mem_wdata", mem_bus.mem_wdata, 64'd0);
    check("rst_mem_size", 64'(mem_bus.mem_size), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_RegWrite", 64'(wb_RegWrite), 64'd0);
    check("rst_wb_Rd", 64'(wb_Rd), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Plain ALU op
    ins = rand_base();
    ins.alu = 64'h1234; ins.rw = 1'b1; ins.op[RD_MSB:RD_LSB] = 5'd5;
    issue(ins, 0, 64'd0, 1'b1);

    // STUR, ack in the fourth request cycle
    ins = rand_base();
    ins.alu = 64'h80; ins.db = 64'hDEAD_BEEF; ins.mw = 1'b1; ins.size = 4'd8;
    issue(ins, 3, {$urandom, $urandom}, 1'b1);

    // LDURB keeps only the low byte
    ins = rand_base();
    ins.re = 1'b1; ins.m2r = 1'b1; ins.rw = 1'b1; ins.ldurb = 1'b1; ins.size = 4'd1;
    issue(ins, 1, 64'hFFFF_FFFF_FFFF_FFA5, 1'b1);

    // MOVK then MOVZ on halfword 2
    ins = rand_base();
    ins.db = 64'h1111_2222_3333_4444; ins.rw = 1'b1; ins.movk = 1'b1;
    ins.op[IMM16_MSB:IMM16_LSB] = 16'hBEEF; ins.op[HW_MSB:HW_LSB] = 2'd2;
    issue(ins, 0, 64'd0, 1'b1);
    ins.movk = 1'b0; ins.movz = 1'b1;
    issue(ins, 0, 64'd0, 1'b1);

    // Back-to-back LDURs acked in their first access cycle
    ins = rand_base();
    ins.re = 1'b1; ins.m2r = 1'b1; ins.rw = 1'b1;
    issue(ins, 0, {$urandom, $urandom}, 1'b1);
    check("req_gap_between_loads", 64'(mem_bus.mem_req), 64'd0);
    ins.alu = {$urandom, $urandom};
    issue(ins, 0, {$urandom, $urandom}, 1'b1);

    // Reset in the second access cycle abandons the load
    @(posedge clk);
    #1;
    ins = rand_base();
    ins.re = 1'b1; ins.m2r = 1'b1; ins.rw = 1'b1;
    begin
      mreq_t r;
      r.we = 1'b0; r.addr = ins.alu; r.wdata = ins.db; r.size = ins.size;
      r.lat = 50; r.rdata = 64'd0;
      mem_q.push_back(r);
    end
    drive(ins, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("req_before_reset", 64'(mem_bus.mem_req), 64'd1);
    reset = 1'b0;
    #1;
    check("req_async_drop", 64'(mem_bus.mem_req), 64'd0);
    check("wb_valid_in_reset", 64'(wb_valid), 64'd0);
    valid_in = 1'b0;
    #1;
    check("stall_in_reset", 64'(stall), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abandoned_req_consumed", 64'(mem_q.size()), 64'd0);

    ins = rand_base();
    ins.rw = 1'b1;
    issue(ins, 0, 64'd0, 1'b1);
    #2 stray_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stall_after_stray_ack", 64'(stall), 64'd0);
    ins = rand_base();
    ins.re = 1'b1; ins.m2r = 1'b1; ins.rw = 1'b1;
    issue(ins, 2, {$urandom, $urandom}, 1'b1);

    // Random instruction mix
    for (int i = 0; i < 300; i++) begin
      ins  = rand_base();
      kind = $urandom_range(0, 6);
      lat  = $urandom_range(0, 4);
      case (kind)
        0: begin ins.mw = 1'($urandom); ins.re = 1'($urandom); ins.rw = 1'($urandom); end
        1: ins.rw = 1'($urandom);
        2: begin ins.movz = 1'b1; ins.rw = 1'b1; end
        3: begin ins.movk = 1'b1; ins.rw = 1'b1; end
        4: begin ins.re = 1'b1; ins.m2r = 1'b1; ins.rw = 1'b1; end
        5: begin ins.re = 1'b1; ins.m2r = 1'b1; ins.rw = 1'b1; ins.ldurb = 1'b1; ins.size = 4'd1; end
        default: begin ins.mw = 1'b1; ins.rw = 1'($urandom); end
      endcase
      issue(ins, lat, {$urandom, $urandom}, kind != 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("mem_queue_drained", 64'(mem_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
